// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86 encodings, pipeline-control state encodings and the hazard/control bundles
// used by pipe_ctrl and its hazard detector.
package pipe_ctrl_pkg;

    localparam int ICODE_W = 4;
    localparam int REG_W   = 4;
    localparam int STAT_W  = 3;

    localparam logic [ICODE_W-1:0] INOP    = 4'h1;
    localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
    localparam logic [ICODE_W-1:0] IRET    = 4'h9;
    localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SHLT = 3'd2;
    localparam logic [STAT_W-1:0] SADR = 3'd3;
    localparam logic [STAT_W-1:0] SINS = 3'd4;

    localparam int PCTL_STATE_W = 2;
    localparam logic [PCTL_STATE_W-1:0] PCTL_RUN      = 2'd0;
    localparam logic [PCTL_STATE_W-1:0] PCTL_RET_WAIT = 2'd1;
    localparam logic [PCTL_STATE_W-1:0] PCTL_HALT     = 2'd2;

    typedef struct packed {
        logic lu;
        logic mp;
        logic rt;
        logic ex_m;
        logic ex_w;
    } hazard_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
    } ctrl_t;

    function automatic logic is_load(input logic [ICODE_W-1:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-status inputs and stall/bubble outputs of the pipeline controller.
// PIPE_PERF_EN adds the performance-counter outputs.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import pipe_ctrl_pkg::*;

    logic [ICODE_W-1:0] D_icode_i;
    logic [ICODE_W-1:0] E_icode_i;
    logic [ICODE_W-1:0] M_icode_i;
    logic [ICODE_W-1:0] W_icode_i;
    logic [REG_W-1:0]   E_dstM_i;
    logic [REG_W-1:0]   d_srcA_i;
    logic [REG_W-1:0]   d_srcB_i;
    logic               e_Cnd_i;
    logic [STAT_W-1:0]  m_stat_i;
    logic [STAT_W-1:0]  W_stat_i;

    logic F_stall_o;
    logic D_stall_o;
    logic D_bubble_o;
    logic E_bubble_o;
    logic M_bubble_o;
    logic W_stall_o;
    logic halted_o;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] perf_cycle_o;
    logic [CNT_W-1:0] perf_stall_o;
    logic [CNT_W-1:0] perf_bubble_o;
    logic [CNT_W-1:0] perf_retire_o;

    modport master (
        output D_icode_i, E_icode_i, M_icode_i, W_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, halted_o,
               perf_cycle_o, perf_stall_o, perf_bubble_o, perf_retire_o
    );
    modport slave (
        input  D_icode_i, E_icode_i, M_icode_i, W_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, halted_o,
               perf_cycle_o, perf_stall_o, perf_bubble_o, perf_retire_o
    );
`else
    // Counter width only matters when the counters exist.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;

    modport master (
        output D_icode_i, E_icode_i, M_icode_i, W_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, halted_o
    );
    modport slave (
        input  D_icode_i, E_icode_i, M_icode_i, W_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, halted_o
    );
`endif

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purely combinational hazard terms: load-use, jXX mispredict, ret in decode,
// and exceptions in memory / writeback.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [ICODE_W-1:0] d_icode,
    input  logic [ICODE_W-1:0] e_icode,
    input  logic [REG_W-1:0]   e_dstm,
    input  logic [REG_W-1:0]   d_src_a,
    input  logic [REG_W-1:0]   d_src_b,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  w_stat,
    output hazard_t            haz
);

    always_comb begin
        haz      = '0;
        // RNONE never creates a dependency, even when decode also reports RNONE.
        haz.lu   = is_load(e_icode) && (e_dstm != RNONE) &&
                   ((e_dstm == d_src_a) || (e_dstm == d_src_b));
        haz.mp   = (e_icode == IJXX) && !e_cnd;
        haz.rt   = (d_icode == IRET);
        haz.ex_m = (m_stat != SAOK);
        haz.ex_w = (w_stat != SAOK);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline stall/bubble control with ret-drain FSM and sticky halt.
// Define PIPE_PERF_EN to add cycle/stall/bubble/retire performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_ctrl_if.slave bus
);

    localparam int RC_W = $clog2(RET_BUBBLES + 1);

    logic [PCTL_STATE_W-1:0] state, state_nxt;
    logic [RC_W-1:0]         ret_cnt, ret_cnt_nxt;
    hazard_t                 haz;
    ctrl_t                   ctl;

    pipe_hazard_detect u_hazard (
        .d_icode (bus.D_icode_i),
        .e_icode (bus.E_icode_i),
        .e_dstm  (bus.E_dstM_i),
        .d_src_a (bus.d_srcA_i),
        .d_src_b (bus.d_srcB_i),
        .e_cnd   (bus.e_Cnd_i),
        .m_stat  (bus.m_stat_i),
        .w_stat  (bus.W_stat_i),
        .haz     (haz)
    );

    always_comb begin
        ctl         = '0;
        state_nxt   = state;
        ret_cnt_nxt = ret_cnt;
        case (state)
            PCTL_RUN: begin
                ctl.f_stall  = haz.lu | (haz.rt & ~haz.mp);
                ctl.d_stall  = haz.lu;
                ctl.d_bubble = haz.mp | (haz.rt & ~haz.lu);
                ctl.e_bubble = haz.mp | haz.lu;
                ctl.m_bubble = haz.ex_m | haz.ex_w;
                ctl.w_stall  = haz.ex_w;
                if (haz.ex_w) begin
                    state_nxt = PCTL_HALT;
                end else if (haz.rt && !haz.lu && !haz.mp && (RET_BUBBLES > 1)) begin
                    // This cycle is the first bubble; the rest drain in RET_WAIT.
                    state_nxt   = PCTL_RET_WAIT;
                    ret_cnt_nxt = RC_W'(RET_BUBBLES - 1);
                end
            end
            PCTL_RET_WAIT: begin
                ctl.f_stall  = 1'b1;
                ctl.d_bubble = 1'b1;
                ctl.m_bubble = haz.ex_m | haz.ex_w;
                ctl.w_stall  = haz.ex_w;
                ret_cnt_nxt  = ret_cnt - RC_W'(1);
                if (haz.ex_w) begin
                    state_nxt = PCTL_HALT;
                end else if (ret_cnt == RC_W'(1)) begin
                    state_nxt = PCTL_RUN;
                end
            end
            PCTL_HALT: begin
                ctl.f_stall  = 1'b1;
                ctl.d_stall  = 1'b1;
                ctl.e_bubble = 1'b1;
                ctl.m_bubble = 1'b1;
                ctl.w_stall  = 1'b1;
            end
            default: begin
                state_nxt = PCTL_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= PCTL_RUN;
            ret_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ret_cnt <= ret_cnt_nxt;
        end
    end

    assign bus.F_stall_o  = ctl.f_stall;
    assign bus.D_stall_o  = ctl.d_stall;
    assign bus.D_bubble_o = ctl.d_bubble;
    assign bus.E_bubble_o = ctl.e_bubble;
    assign bus.M_bubble_o = ctl.m_bubble;
    assign bus.W_stall_o  = ctl.w_stall;
    assign bus.halted_o   = (state == PCTL_HALT);

    // M_icode is not needed for control here; W_icode only feeds the retire counter.
    logic unused_icodes;
    assign unused_icodes = ^{bus.M_icode_i, bus.W_icode_i};

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] perf_cycle, perf_stall, perf_bubble, perf_retire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cycle  <= '0;
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_retire <= '0;
        end else if (state != PCTL_HALT) begin
            perf_cycle <= perf_cycle + CNT_W'(1);
            if (ctl.f_stall)
                perf_stall <= perf_stall + CNT_W'(1);
            if (ctl.d_bubble || ctl.e_bubble)
                perf_bubble <= perf_bubble + CNT_W'(1);
            if ((bus.W_icode_i != INOP) && (bus.W_stat_i == SAOK))
                perf_retire <= perf_retire + CNT_W'(1);
        end
    end

    assign bus.perf_cycle_o  = perf_cycle;
    assign bus.perf_stall_o  = perf_stall;
    assign bus.perf_bubble_o = perf_bubble;
    assign bus.perf_retire_o = perf_retire;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: expected control vectors are queued with each stimulus
// cycle and popped/compared when the outputs are sampled.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [3:0] IOPQ_C = 4'h6;
    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted}
    localparam logic [6:0] V_IDLE = 7'b0000000;
    localparam logic [6:0] V_LU   = 7'b1101000;
    localparam logic [6:0] V_RET  = 7'b1010000;
    localparam logic [6:0] V_MP   = 7'b0011000;
    localparam logic [6:0] V_EXM  = 7'b0000100;
    localparam logic [6:0] V_EXW  = 7'b0000110;
    localparam logic [6:0] V_HALT = 7'b1101111;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [6:0] exp_q[$];
    logic [6:0] got;
    logic [6:0] want;

    pipe_ctrl_if #(.CNT_W(32)) pif ();

    pipe_ctrl #(.RET_BUBBLES(3), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_now();
        return {pif.F_stall_o, pif.D_stall_o, pif.D_bubble_o, pif.E_bubble_o,
                pif.M_bubble_o, pif.W_stall_o, pif.halted_o};
    endfunction

    task automatic idle();
        pif.D_icode_i = INOP;
        pif.E_icode_i = INOP;
        pif.M_icode_i = INOP;
        pif.W_icode_i = INOP;
        pif.E_dstM_i  = RNONE;
        pif.d_srcA_i  = RNONE;
        pif.d_srcB_i  = RNONE;
        pif.e_Cnd_i   = 1'b1;
        pif.m_stat_i  = SAOK;
        pif.W_stat_i  = SAOK;
    endtask

    task automatic load_use(input logic [3:0] icode, input logic [3:0] dst,
                            input logic [3:0] sa, input logic [3:0] sb);
        pif.E_icode_i = icode;
        pif.E_dstM_i  = dst;
        pif.d_srcA_i  = sa;
        pif.d_srcB_i  = sb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(V_IDLE);
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL reset cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 10; i++) begin
            idle();
            case (i)
                0: begin load_use(IMRMOVQ, 4'd3, 4'd3, RNONE); exp_q.push_back(V_LU); end
                1: begin load_use(IPOPQ, 4'd5, 4'd1, 4'd5);    exp_q.push_back(V_LU); end
                2: begin load_use(IMRMOVQ, RNONE, RNONE, RNONE); exp_q.push_back(V_IDLE); end
                3: begin load_use(IMRMOVQ, 4'd3, 4'd4, 4'd5);  exp_q.push_back(V_IDLE); end
                4: begin load_use(IOPQ_C, 4'd3, 4'd3, 4'd3);   exp_q.push_back(V_IDLE); end
                5: begin load_use(IMRMOVQ, 4'd3, 4'd3, RNONE); pif.D_icode_i = IRET;
                         exp_q.push_back(V_LU); end
                6: begin pif.D_icode_i = IRET; exp_q.push_back(V_RET); end
                7, 8: exp_q.push_back(V_RET);
                default: exp_q.push_back(V_IDLE);
            endcase
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL load_use cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ret();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin pif.D_icode_i = IRET; exp_q.push_back(V_RET); end
                1: begin load_use(IMRMOVQ, 4'd3, 4'd3, RNONE); exp_q.push_back(V_RET); end
                2: begin pif.m_stat_i = SINS; exp_q.push_back(V_RET | V_EXM); end
                default: exp_q.push_back(V_IDLE);
            endcase
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL ret cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 0 || i == 3) pif.D_icode_i = IRET;
            exp_q.push_back((i < 6) ? V_RET : V_IDLE);
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL back_to_back cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mispredict();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin pif.D_icode_i = IRET; pif.E_icode_i = IJXX; pif.e_Cnd_i = 1'b0;
                         exp_q.push_back(V_MP); end
                2: begin pif.E_icode_i = IJXX; pif.e_Cnd_i = 1'b1; exp_q.push_back(V_IDLE); end
                3: begin pif.E_icode_i = IJXX; pif.e_Cnd_i = 1'b0; exp_q.push_back(V_MP); end
                default: exp_q.push_back(V_IDLE);
            endcase
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL mispredict cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ex_m();
        for (int i = 0; i < 2; i++) begin
            idle();
            if (i == 0) pif.m_stat_i = SINS;
            exp_q.push_back((i == 0) ? V_EXM : V_IDLE);
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL ex_m cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 14; i++) begin
            idle();
            case (i)
                0: begin pif.D_icode_i = IRET; exp_q.push_back(V_RET); end
                1: begin pif.W_stat_i = SADR; exp_q.push_back(V_RET | V_EXW); end
                3: begin pif.D_icode_i = IRET; pif.E_icode_i = IJXX; pif.e_Cnd_i = 1'b0;
                         exp_q.push_back(V_HALT); end
                default: exp_q.push_back(V_HALT);
            endcase
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL halt cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_halt();
        for (int i = 0; i < 8; i++) begin
            idle();
            rst = (i == 0 || i == 6);
            case (i)
                0, 5, 6: exp_q.push_back(V_HALT);
                2: begin pif.m_stat_i = SINS; exp_q.push_back(V_EXM); end
                4: begin pif.W_stat_i = SADR; exp_q.push_back(V_EXW); end
                default: exp_q.push_back(V_IDLE);
            endcase
            #1;
            got = ctl_now(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL reset_halt cyc%0d got=%b want=%b", i, got, want);
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

`ifdef PIPE_PERF_EN
    task automatic test_perf();
        logic [127:0] got_p;
        logic [127:0] want_p;
        logic [127:0] perf_q[$];
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (i == 10) pif.D_icode_i = IRET;
            if (i >= 20 && i < 25) pif.W_icode_i = IOPQ_C;
            @(negedge clk);
        end
        perf_q.push_back({32'd100, 32'd3, 32'd3, 32'd5});
        got_p = {pif.perf_cycle_o, pif.perf_stall_o, pif.perf_bubble_o, pif.perf_retire_o};
        want_p = perf_q.pop_front(); total++;
        if (got_p !== want_p) begin
            bad++; $display("FAIL perf_run got=%h want=%h", got_p, want_p);
        end
        idle();
        pif.W_stat_i = SADR;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            idle();
            pif.W_icode_i = IOPQ_C;
            @(negedge clk);
        end
        perf_q.push_back({32'd101, 32'd3, 32'd3, 32'd5});
        got_p = {pif.perf_cycle_o, pif.perf_stall_o, pif.perf_bubble_o, pif.perf_retire_o};
        want_p = perf_q.pop_front(); total++;
        if (got_p !== want_p) begin
            bad++; $display("FAIL perf_frozen got=%h want=%h", got_p, want_p);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_ret();
        test_back_to_back();
        test_mispredict();
        test_ex_m();
        test_halt();
        test_reset_halt();
`ifdef PIPE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
